lcd_ctrl: RTL and testbench
===========================

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter T_PWR, default 750000, power-on wait in clk_i cycles (15 ms at 50 MHz).
REQ-002 Parameter T_SU, default 3, RS/data setup before EN rise, in cycles.
REQ-003 Parameter T_EN, default 12, EN high pulse width, in cycles.
REQ-004 Parameter T_HOLD, default 2, RS/data hold after EN fall, in cycles.
REQ-005 Parameter T_EXEC, default 2000, normal command execution wait (40 us), in cycles.
REQ-006 Parameter T_EXEC_LONG, default 82000, clear/home execution wait (1.64 ms), in cycles.
REQ-007 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-008 rst_ni  in  1  asynchronous, active-low reset.
REQ-009 cmd_valid_i  in  1  requester has a byte to send.
REQ-010 cmd_rs_i  in  1  register select: 0 = instruction, 1 = data.
REQ-011 cmd_data_i  in  8  byte to send.
REQ-012 cmd_ready_o  out  1  controller can accept a byte this cycle.
REQ-013 io_lcd_o  out  12  panel bus: [11] ON, [10] EN, [9] RS, [8] RW, [7:0] DATA.
REQ-014 init_done_o  out  1  power-on init sequence complete (sticky).
REQ-015 busy_o  out  1  high in every state except IDLE.

Function
REQ-016 States: PWR_WAIT, SETUP, PULSE, HOLD, EXEC, IDLE; init commands reuse SETUP..EXEC, selected by init index 0..4.
REQ-017 After reset release, PWR_WAIT lasts exactly T_PWR cycles, then the first init command enters SETUP.
REQ-018 Init ROM, in order: 0x38, 0x38, 0x0C, 0x01, 0x06, all with RS=0; after EXEC of index 4, go to IDLE and set init_done_o=1.
REQ-019 cmd_ready_o = 1 only in IDLE; a transfer occurs when cmd_valid_i && cmd_ready_o, latching cmd_rs_i/cmd_data_i.
REQ-020 Cycle of acceptance N: state SETUP from N+1; RS/DATA carry the latched values from N+1.
REQ-021 SETUP lasts T_SU cycles (EN=0), PULSE T_EN cycles (EN=1), HOLD T_HOLD cycles (EN=0), EXEC T_EXEC or T_EXEC_LONG cycles (EN=0), then IDLE.
REQ-022 Accept-to-next-ready = T_SU+T_EN+T_HOLD+Texec+1 cycles; back-to-back valid is accepted on the first IDLE cycle.
REQ-023 T_EXEC_LONG applies when RS=0 and data is 0x01, 0x02 or 0x03; all other bytes use T_EXEC.
REQ-024 RS/DATA are held constant from SETUP entry through EXEC end; in IDLE they keep the last sent value.
REQ-025 RW (bit 8) is constant 0; ON (bit 11) is 1 in every cycle after reset release.
REQ-026 cmd_valid_i during PWR_WAIT or init is ignored (ready low); no input is lost once accepted.
REQ-027 All timing parameters are >= 1; the counter width is $clog2 of the largest parameter plus 1.

Reset
REQ-028 Asserting rst_ni low forces immediately: io_lcd_o=12'h000, cmd_ready_o=0, busy_o=1, init_done_o=0, state PWR_WAIT, init index 0, counter 0.
REQ-029 Reset mid-pulse drops EN asynchronously; after release, the full power-on sequence restarts.

Structure
REQ-030 Package lcd_ctrl_pkg holds the state enum, the io_lcd_o bit-position constants and the 5-entry init command ROM constant.
REQ-031 One sub-module lcd_timer: loadable down-counter with load_i, value_i and done_o (count reached 1), instantiated once.

Verification (bench parameters T_PWR=10, T_SU=2, T_EN=3, T_HOLD=1, T_EXEC=5, T_EXEC_LONG=20)
REQ-032 Reset release -> 10 cycles of EN=0 with ON=1, then 5 EN pulses with DATA 0x38, 0x38, 0x0C, 0x01, 0x06; the 0x01 gap is 20 cycles; init_done_o=1 afterward.
REQ-033 In IDLE, send RS=1 data 0x41 -> RS=1 and DATA=0x41 for 11 cycles; EN high exactly 3 cycles starting 2 cycles after the SETUP cycle; ready returns after 12 cycles.
REQ-034 Send RS=0 data 0x01 -> EXEC lasts 20 cycles; RS=0 data 0x80 -> EXEC lasts 5 cycles; RS=1 data 0x01 -> EXEC lasts 5 cycles.
REQ-035 Hold cmd_valid_i high continuously from reset with data 0x55 -> nothing is accepted until init_done_o; then one accept every 12 cycles.
REQ-036 Assert rst_ni low during PULSE -> io_lcd_o = 0 in the same cycle; after release, the init sequence from REQ-032 repeats exactly.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// ============================================================================
// Module   : lcd_ctrl_pkg
// Brief    : Shared types and constants for the HD44780-style LCD controller:
//            FSM state enum, panel bus bit positions and the init ROM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT = 3'd0,
        SETUP    = 3'd1,
        PULSE    = 3'd2,
        HOLD     = 3'd3,
        EXEC     = 3'd4,
        IDLE     = 3'd5
    } lcd_state_t;

    // Panel bus bit positions
    localparam int LCD_ON_BIT   = 11;
    localparam int LCD_EN_BIT   = 10;
    localparam int LCD_RS_BIT   = 9;
    localparam int LCD_RW_BIT   = 8;
    localparam int LCD_DATA_LSB = 0;

    // Power-on init sequence: function set, function set, display on,
    // clear, entry mode. All are instructions (RS=0).
    localparam int INIT_LEN = 5;
    localparam logic [0:INIT_LEN-1][7:0] INIT_ROM = {
        8'h38, 8'h38, 8'h0C, 8'h01, 8'h06
    };

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_timer.sv
// ============================================================================
// Module   : lcd_timer
// Brief    : Loadable down-counter. done_o flags the last cycle of an
//            interval: loading N gives exactly N cycles until done_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);

    logic [W-1:0] count;

    // Load takes priority; otherwise count down and rest at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (load_i) begin
            count <= value_i;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done_o = (count == W'(1));

endmodule

`default_nettype wire

// File: rtl/lcd_ctrl.sv
// ============================================================================
// Module   : lcd_ctrl
// Brief    : Character LCD bus controller. Waits for panel power-up, plays
//            the init ROM, then sends requester bytes with setup / enable
//            pulse / hold / execution timing on a 12-bit panel bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int T_PWR       = 750000,
    parameter int T_SU        = 3,
    parameter int T_EN        = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    input  logic        cmd_rs_i,
    input  logic [7:0]  cmd_data_i,
    output logic        cmd_ready_o,
    output logic [11:0] io_lcd_o,
    output logic        init_done_o,
    output logic        busy_o
);

    localparam int T_MAX = max_of(max_of(max_of(T_PWR, T_SU), max_of(T_EN, T_HOLD)),
                                  max_of(T_EXEC, T_EXEC_LONG));
    localparam int CW    = $clog2(T_MAX) + 1;

    lcd_state_t    state, state_next;
    logic          on_q;
    logic          rs_q;
    logic [7:0]    data_q;
    logic [2:0]    init_idx;
    logic [2:0]    idx_next;
    logic          init_done_q;

    logic          tmr_load;
    logic [CW-1:0] tmr_value;
    logic          tmr_done;

    logic          start_init;
    logic          next_init;
    logic          finish_init;
    logic          accept;

    assign idx_next = init_idx + 3'd1;

    lcd_timer #(.W(CW)) u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .done_o  (tmr_done)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= PWR_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and timer reloads; each state loads the timer with
    // the duration of the state it hands over to.
    always_comb begin
        state_next  = state;
        tmr_load    = 1'b0;
        tmr_value   = '0;
        start_init  = 1'b0;
        next_init   = 1'b0;
        finish_init = 1'b0;
        accept      = 1'b0;
        case (state)
            PWR_WAIT: begin
                // on_q is still low on the first clock after reset release,
                // which is where the power-on interval is armed.
                if (!on_q) begin
                    tmr_load  = 1'b1;
                    tmr_value = CW'(T_PWR);
                end else if (tmr_done) begin
                    state_next = SETUP;
                    tmr_load   = 1'b1;
                    tmr_value  = CW'(T_SU);
                    start_init = 1'b1;
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    state_next = PULSE;
                    tmr_load   = 1'b1;
                    tmr_value  = CW'(T_EN);
                end
            end
            PULSE: begin
                if (tmr_done) begin
                    state_next = HOLD;
                    tmr_load   = 1'b1;
                    tmr_value  = CW'(T_HOLD);
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    state_next = EXEC;
                    tmr_load   = 1'b1;
                    tmr_value  = is_long_cmd(rs_q, data_q) ? CW'(T_EXEC_LONG) : CW'(T_EXEC);
                end
            end
            EXEC: begin
                if (tmr_done) begin
                    if (init_done_q) begin
                        state_next = IDLE;
                    end else if (init_idx == 3'(INIT_LEN - 1)) begin
                        state_next  = IDLE;
                        finish_init = 1'b1;
                    end else begin
                        state_next = SETUP;
                        tmr_load   = 1'b1;
                        tmr_value  = CW'(T_SU);
                        next_init  = 1'b1;
                    end
                end
            end
            IDLE: begin
                if (cmd_valid_i) begin
                    state_next = SETUP;
                    tmr_load   = 1'b1;
                    tmr_value  = CW'(T_SU);
                    accept     = 1'b1;
                end
            end
            default: begin
                state_next = PWR_WAIT;
            end
        endcase
    end

    // Bus byte, init progress and the sticky status flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            on_q        <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            init_idx    <= 3'd0;
            init_done_q <= 1'b0;
        end else begin
            on_q <= 1'b1;
            if (start_init) begin
                rs_q     <= 1'b0;
                data_q   <= INIT_ROM[0];
                init_idx <= 3'd0;
            end
            if (next_init) begin
                init_idx <= idx_next;
                data_q   <= INIT_ROM[idx_next];
            end
            if (accept) begin
                rs_q   <= cmd_rs_i;
                data_q <= cmd_data_i;
            end
            if (finish_init) begin
                init_done_q <= 1'b1;
            end
        end
    end

    // Panel bus assembly; EN follows the state register so reset drops it at once
    always_comb begin
        io_lcd_o                          = '0;
        io_lcd_o[LCD_ON_BIT]              = on_q;
        io_lcd_o[LCD_EN_BIT]              = (state == PULSE);
        io_lcd_o[LCD_RS_BIT]              = rs_q;
        io_lcd_o[LCD_RW_BIT]              = 1'b0;
        io_lcd_o[LCD_DATA_LSB +: 8]       = data_q;
    end

    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign init_done_o = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
// ============================================================================
// Module   : tb_lcd_ctrl
// Brief    : Self-checking bench for lcd_ctrl: init sequence, table-driven
//            and random transfers, back-to-back requests, reset mid-pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lcd_ctrl;

    localparam int P_PWR  = 10;
    localparam int P_SU   = 2;
    localparam int P_EN   = 3;
    localparam int P_HOLD = 1;
    localparam int P_EX   = 5;
    localparam int P_EXL  = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_rs;
    logic [7:0]  cmd_data;
    logic        cmd_ready;
    logic [11:0] io_lcd;
    logic        init_done;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         exec_len;
    } vec_t;

    vec_t vecs[8];
    logic [7:0] init_seq[5];

    lcd_ctrl #(
        .T_PWR       (P_PWR),
        .T_SU        (P_SU),
        .T_EN        (P_EN),
        .T_HOLD      (P_HOLD),
        .T_EXEC      (P_EX),
        .T_EXEC_LONG (P_EXL)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_rs_i    (cmd_rs),
        .cmd_data_i  (cmd_data),
        .cmd_ready_o (cmd_ready),
        .io_lcd_o    (io_lcd),
        .init_done_o (init_done),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: how long a byte's execution wait lasts
    function automatic int model_exec(input logic rs, input logic [7:0] data);
        if (rs == 1'b0 && data >= 8'h01 && data <= 8'h03) return P_EXL;
        return P_EX;
    endfunction

    // Reference model: panel bus k cycles (1-based) into a transfer
    function automatic logic [11:0] model_bus(input int k, input logic rs, input logic [7:0] data);
        logic en;
        en = (k > P_SU) && (k <= P_SU + P_EN);
        return {1'b1, en, rs, 1'b0, data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check one complete transfer starting at the first sample after its
    // launch edge; returns at the first sample where ready is expected back.
    task automatic check_xfer(input string tag, input logic rs, input logic [7:0] data,
                              input int exec_len, input logic in_init);
        int d;
        d = P_SU + P_EN + P_HOLD + exec_len;
        for (int k = 1; k <= d; k++) begin
            chk({tag, "_bus"}, 32'(io_lcd), 32'(model_bus(k, rs, data)));
            chk({tag, "_ready_low"}, 32'(cmd_ready), 32'd0);
            if (in_init) chk({tag, "_init_done_low"}, 32'(init_done), 32'd0);
            step();
        end
    endtask

    // Release happens elsewhere; this checks the whole power-on sequence.
    task automatic check_init(input string tag);
        for (int k = 1; k <= P_PWR; k++) begin
            step();
            chk({tag, "_pwr_bus"}, 32'(io_lcd), 32'h800);
            chk({tag, "_pwr_ready"}, 32'(cmd_ready), 32'd0);
        end
        step();
        for (int i = 0; i < 5; i++) begin
            check_xfer({tag, "_init"}, 1'b0, init_seq[i], model_exec(1'b0, init_seq[i]), 1'b1);
        end
        chk({tag, "_init_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_init_done"}, 32'(init_done), 32'd1);
        chk({tag, "_init_busy"}, 32'(busy), 32'd0);
        chk({tag, "_init_idle_bus"}, 32'(io_lcd), 32'h806);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300 && !cmd_ready; i++) step();
        if (!cmd_ready) chk("wait_ready_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic send(input string tag, input logic rs, input logic [7:0] data, input int exec_len);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_rs    = rs;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        cmd_rs    = 1'($urandom);
        cmd_data  = 8'($urandom);
        check_xfer(tag, rs, data, exec_len, 1'b0);
        chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_idle_bus"}, 32'(io_lcd), 32'({1'b1, 1'b0, rs, 1'b0, data}));
    endtask

    initial begin
        int per;
        logic rs_r;
        logic [7:0] d_r;

        init_seq[0] = 8'h38; init_seq[1] = 8'h38; init_seq[2] = 8'h0C;
        init_seq[3] = 8'h01; init_seq[4] = 8'h06;

        vecs[0] = '{1'b1, 8'h41, 5};
        vecs[1] = '{1'b0, 8'h01, 20};
        vecs[2] = '{1'b0, 8'h80, 5};
        vecs[3] = '{1'b1, 8'h01, 5};
        vecs[4] = '{1'b0, 8'h02, 20};
        vecs[5] = '{1'b0, 8'h03, 20};
        vecs[6] = '{1'b0, 8'h04, 5};
        vecs[7] = '{1'b0, 8'h00, 5};

        cmd_valid = 1'b0;
        cmd_rs    = 1'b0;
        cmd_data  = 8'h00;
        rst_n     = 1'b1;
        #3 rst_n  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bus", 32'(io_lcd), 32'h000);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_init_done", 32'(init_done), 32'd0);

        // Power-on sequence
        rst_n = 1'b1;
        check_init("por");

        // Table-driven transfers
        foreach (vecs[i]) begin
            send($sformatf("vec%0d", i), vecs[i].rs, vecs[i].data, vecs[i].exec_len);
        end

        // Random transfers against the reference model, with random idle gaps
        for (int n = 0; n < 25; n++) begin
            rs_r = 1'($urandom);
            d_r  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            repeat ($urandom_range(0, 3)) step();
            send($sformatf("rnd%0d", n), rs_r, d_r, model_exec(rs_r, d_r));
        end

        // Reset in the middle of an enable pulse
        wait_ready();
        cmd_valid = 1'b1;
        cmd_rs    = 1'b1;
        cmd_data  = 8'h5A;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !io_lcd[10]; i++) step();
        chk("midpulse_en_seen", 32'(io_lcd[10]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midpulse_rst_bus", 32'(io_lcd), 32'h000);
        chk("midpulse_rst_ready", 32'(cmd_ready), 32'd0);
        chk("midpulse_rst_busy", 32'(busy), 32'd1);
        chk("midpulse_rst_init_done", 32'(init_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_init("rerun");

        // Valid held high from reset: ignored through init, then one accept per period
        cmd_valid = 1'b1;
        cmd_rs    = 1'b1;
        cmd_data  = 8'h55;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_init("hold");
        per = P_SU + P_EN + P_HOLD + P_EX + 1;
        for (int t = 1; t <= 3 * per; t++) begin
            step();
            chk("hold_ready_period", 32'(cmd_ready), 32'((t % per) == 0));
            chk("hold_bus_byte", 32'(io_lcd[9:0]), 32'({1'b1, 1'b0, 8'h55}));
        end
        cmd_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
